mux_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the 8:1 mux datapath among eight requesters. It arbitrates the `req_in` lines and drives the mux `selection_in` with the winner's index. It holds each grant for a bounded burst of accepted beats, then rotates priority. It sits directly in front of the `mux8to1` select port and produces the valid/grant qualifiers the consumer of `mux_out` needs.

---
 rtl/mux_rr_scheduler.sv | 133 +++++++++++++
 tb/tb_mux_rr_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin owner selection for an 8:1 mux datapath.
// Each grant lasts up to BURST_MAX accepted beats. On release the scheduler
// rearbitrates in the same edge, starting from owner+1, so there is no idle
// bubble. valid_out is the only combinational output.
module mux_rr_scheduler #(
  parameter int N         = 8,
  parameter int SEL_W     = 3,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask_in,
  input  logic             out_ready_in,
  output logic [SEL_W-1:0] selection_out,
  output logic [N-1:0]     grant_out,
  output logic             valid_out,
  output logic [3:0]       beat_cnt_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [SEL_W-1:0] last, last_nxt;
  logic [N-1:0]     grant, grant_nxt;
  logic [3:0]       cnt, cnt_nxt;

  logic [N-1:0]     elig;
  logic [SEL_W-1:0] winner;
  logic             valid;
  logic             accept;
  logic             burst_end;
  logic             rel;

  // The first set bit of e, scanning upward from start and wrapping.
  // N is a power of two, so SEL_W-bit addition wraps modulo N for free.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0]     e,
                                               input logic [SEL_W-1:0] start);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    found = 1'b0;
    pick  = start;
    for (int i = 0; i < N; i++) begin
      idx = start + SEL_W'(i);
      if (!found && e[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  assign elig = req_in & mask_in;
  // While BUSY, last always equals the owner, so last+1 is also owner+1.
  assign winner = rr_pick(elig, last + SEL_W'(1));

  // valid follows the owner's live request, so a dropped request produces
  // no beat in that same cycle.
  assign valid     = (state == BUSY) && req_in[sel];
  assign accept    = valid && out_ready_in;
  assign burst_end = accept && (cnt == 4'(BURST_MAX - 1));
  // A drop and a burst end in the same cycle are one release. The count is
  // reloaded instead of being incremented.
  assign rel       = !req_in[sel] || !mask_in[sel] || burst_end;

  // Next-state, owner and beat-count logic. By default everything holds.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|elig) begin
          state_nxt = BUSY;
          sel_nxt   = winner;
          last_nxt  = winner;
          grant_nxt = {{(N-1){1'b0}}, 1'b1} << winner;
          cnt_nxt   = 4'd0;
        end
      end
      BUSY: begin
        if (rel) begin
          if (|elig) begin
            sel_nxt   = winner;
            last_nxt  = winner;
            grant_nxt = {{(N-1){1'b0}}, 1'b1} << winner;
            cnt_nxt   = 4'd0;
          end else begin
            // selection_out keeps its last value while idle.
            state_nxt = IDLE;
            grant_nxt = '0;
            cnt_nxt   = 4'd0;
          end
        end else if (accept) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State register. The asynchronous reset sets last to N-1, which gives
  // requester 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      last  <= SEL_W'(N - 1);
      grant <= '0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      last  <= last_nxt;
      grant <= grant_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign selection_out = sel;
  assign grant_out     = grant;
  assign valid_out     = valid;
  assign beat_cnt_out  = cnt;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed testbench for mux_rr_scheduler with BURST_MAX = 4.
module tb_mux_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mask_in;
  logic       out_ready_in;
  logic [2:0] selection_out;
  logic [7:0] grant_out;
  logic       valid_out;
  logic [3:0] beat_cnt_out;

  int total = 0;
  int bad   = 0;

  int rdy_seq [7] = '{1, 0, 0, 1, 1, 0, 1};
  int cnt_seq [7] = '{1, 1, 1, 2, 3, 3, 0};

  mux_rr_scheduler #(.N(8), .SEL_W(3), .BURST_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_in       (req_in),
    .mask_in      (mask_in),
    .out_ready_in (out_ready_in),
    .selection_out(selection_out),
    .grant_out    (grant_out),
    .valid_out    (valid_out),
    .beat_cnt_out (beat_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put the scheduler in its reset state with no requests pending.
  task automatic do_reset();
    rst_n = 1'b0; req_in = 8'h00; mask_in = 8'hFF; out_ready_in = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_in = 8'hFF; mask_in = 8'hFF; out_ready_in = 1'b1;
    step();
    step();
    total++; if (grant_out !== 8'h00) begin bad++; $display("FAIL rst_grant got=%h exp=00", grant_out); end
    total++; if (selection_out !== 3'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", selection_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
    total++; if (beat_cnt_out !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", beat_cnt_out); end
    rst_n = 1'b1;
    step();
    total++; if (grant_out !== 8'h01) begin bad++; $display("FAIL rst_first_grant got=%h exp=01", grant_out); end
    total++; if (selection_out !== 3'd0) begin bad++; $display("FAIL rst_first_sel got=%0d exp=0", selection_out); end
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL rst_first_valid got=%b exp=1", valid_out); end
  endtask

  task automatic test_idle();
    do_reset();
    step();
    step();
    total++; if (grant_out !== 8'h00) begin bad++; $display("FAIL idle_grant got=%h exp=00", grant_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", valid_out); end
  endtask

  task automatic test_rotation();
    logic [2:0] o;
    do_reset();
    req_in = 8'hFF; mask_in = 8'hFF; out_ready_in = 1'b1;
    step();
    for (int k = 0; k < 9; k++) begin
      o = 3'(k);
      total++; if (grant_out !== (8'h01 << o)) begin bad++; $display("FAIL rot_grant owner=%0d got=%h exp=%h", o, grant_out, 8'h01 << o); end
      for (int b = 0; b < 4; b++) begin
        total++; if (selection_out !== o) begin bad++; $display("FAIL rot_sel beat=%0d got=%0d exp=%0d", b, selection_out, o); end
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL rot_valid owner=%0d beat=%0d got=%b exp=1", o, b, valid_out); end
        total++; if (beat_cnt_out !== 4'(b)) begin bad++; $display("FAIL rot_cnt owner=%0d got=%0d exp=%0d", o, beat_cnt_out, b); end
        step();
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_in = 8'h08; mask_in = 8'hFF; out_ready_in = 1'b1;
    step();
    total++; if (selection_out !== 3'd3) begin bad++; $display("FAIL stall_start_sel got=%0d exp=3", selection_out); end
    total++; if (beat_cnt_out !== 4'd0) begin bad++; $display("FAIL stall_start_cnt got=%0d exp=0", beat_cnt_out); end
    for (int k = 0; k < 7; k++) begin
      out_ready_in = rdy_seq[k][0];
      step();
      total++; if (beat_cnt_out !== 4'(cnt_seq[k])) begin bad++; $display("FAIL stall_cnt step=%0d got=%0d exp=%0d", k, beat_cnt_out, cnt_seq[k]); end
      total++; if (selection_out !== 3'd3) begin bad++; $display("FAIL stall_sel step=%0d got=%0d exp=3", k, selection_out); end
      total++; if (grant_out !== 8'h08) begin bad++; $display("FAIL stall_grant step=%0d got=%h exp=08", k, grant_out); end
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    req_in = 8'h20; mask_in = 8'hFF; out_ready_in = 1'b1;
    step();
    total++; if (selection_out !== 3'd5) begin bad++; $display("FAIL drop_owner got=%0d exp=5", selection_out); end
    req_in = 8'h24;
    step();
    step();
    total++; if (beat_cnt_out !== 4'd2) begin bad++; $display("FAIL drop_cnt got=%0d exp=2", beat_cnt_out); end
    req_in = 8'h04;
    #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b exp=0", valid_out); end
    total++; if (selection_out !== 3'd5) begin bad++; $display("FAIL drop_sel_hold got=%0d exp=5", selection_out); end
    step();
    total++; if (grant_out !== 8'h04) begin bad++; $display("FAIL drop_regrant got=%h exp=04", grant_out); end
    total++; if (selection_out !== 3'd2) begin bad++; $display("FAIL drop_sel_new got=%0d exp=2", selection_out); end
    total++; if (beat_cnt_out !== 4'd0) begin bad++; $display("FAIL drop_cnt_new got=%0d exp=0", beat_cnt_out); end
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL drop_valid_new got=%b exp=1", valid_out); end
    req_in = 8'h00;
    step();
    total++; if (grant_out !== 8'h00) begin bad++; $display("FAIL goidle_grant got=%h exp=00", grant_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL goidle_valid got=%b exp=0", valid_out); end
    total++; if (selection_out !== 3'd2) begin bad++; $display("FAIL goidle_sel got=%0d exp=2", selection_out); end
  endtask

  task automatic test_mask();
    do_reset();
    req_in = 8'h81; mask_in = 8'hFE; out_ready_in = 1'b1;
    step();
    for (int b = 0; b < 4; b++) begin
      total++; if (selection_out !== 3'd7) begin bad++; $display("FAIL mask_sel beat=%0d got=%0d exp=7", b, selection_out); end
      total++; if (beat_cnt_out !== 4'(b)) begin bad++; $display("FAIL mask_cnt beat=%0d got=%0d exp=%0d", b, beat_cnt_out, b); end
      step();
    end
    total++; if (grant_out !== 8'h80) begin bad++; $display("FAIL mask_regrant got=%h exp=80", grant_out); end
    total++; if (beat_cnt_out !== 4'd0) begin bad++; $display("FAIL mask_regrant_cnt got=%0d exp=0", beat_cnt_out); end
    step();
    step();
    mask_in = 8'hFF;
    #1;
    total++; if (selection_out !== 3'd7) begin bad++; $display("FAIL mask_clear_sel got=%0d exp=7", selection_out); end
    total++; if (beat_cnt_out !== 4'd2) begin bad++; $display("FAIL mask_clear_cnt got=%0d exp=2", beat_cnt_out); end
    step();
    total++; if (selection_out !== 3'd7) begin bad++; $display("FAIL mask_hold_sel got=%0d exp=7", selection_out); end
    total++; if (beat_cnt_out !== 4'd3) begin bad++; $display("FAIL mask_hold_cnt got=%0d exp=3", beat_cnt_out); end
    step();
    total++; if (grant_out !== 8'h01) begin bad++; $display("FAIL mask_release_grant got=%h exp=01", grant_out); end
    total++; if (selection_out !== 3'd0) begin bad++; $display("FAIL mask_release_sel got=%0d exp=0", selection_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_in = 8'h40; mask_in = 8'hFF; out_ready_in = 1'b1;
    step();
    step();
    step();
    total++; if (selection_out !== 3'd6) begin bad++; $display("FAIL midrst_pre_sel got=%0d exp=6", selection_out); end
    total++; if (beat_cnt_out !== 4'd2) begin bad++; $display("FAIL midrst_pre_cnt got=%0d exp=2", beat_cnt_out); end
    rst_n = 1'b0;
    #2;
    total++; if (grant_out !== 8'h00) begin bad++; $display("FAIL midrst_grant got=%h exp=00", grant_out); end
    total++; if (selection_out !== 3'd0) begin bad++; $display("FAIL midrst_sel got=%0d exp=0", selection_out); end
    total++; if (beat_cnt_out !== 4'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", beat_cnt_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", valid_out); end
    req_in = 8'hFF;
    step();
    rst_n = 1'b1;
    step();
    total++; if (grant_out !== 8'h01) begin bad++; $display("FAIL midrst_first_grant got=%h exp=01", grant_out); end
    total++; if (selection_out !== 3'd0) begin bad++; $display("FAIL midrst_first_sel got=%0d exp=0", selection_out); end
  endtask

  initial begin
    rst_n = 1'b0; req_in = 8'h00; mask_in = 8'hFF; out_ready_in = 1'b0;
    test_reset();
    test_idle();
    test_rotation();
    test_stall();
    test_early_drop();
    test_mask();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
